// File: rtl/cache_pkg.sv
// cache_pkg: shared state, counter type and address-field widths for cache_way.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
package cache_pkg;
    typedef enum logic [1:0] {IDLE, FILL, EVICT} cache_way_state_e;
    typedef logic [15:0] beat_cnt_t;
    function automatic int word_bits(input int line_words);
        return $clog2(line_words);
    endfunction
    function automatic int set_bits(input int set_depth);
        return $clog2(set_depth);
    endfunction
    function automatic int tag_bits(input int dw, input int line_words, input int set_depth);
        return dw - 2 - word_bits(line_words) - set_bits(set_depth);
    endfunction
endpackage

// File: rtl/cache_way_ram.sv
// cache_way_ram: line storage with one registered read port and one byte-enable write port.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
module cache_way_ram #(
    parameter int DW    = `DATA_WIDTH,
    parameter int DEPTH = 128,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   raddr,
    output logic [DW-1:0]   rdata,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [DW-1:0]   wdata,
    input  logic [DW/8-1:0] be
);
    logic [DW-1:0] mem [DEPTH];
    always_ff @(posedge clk)
        if (we)
            for (int b = 0; b < DW / 8; b++)
                if (be[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
    always_ff @(posedge clk)
        rdata <= rst ? '0 : mem[raddr];
endmodule

// File: rtl/cache_way.sv
// cache_way: one way of a set-associative cache with burst fill/evict sequencers.
// Define CACHE_WAY_NRU_EN to add per-set NRU bits; otherwise nru is tied low.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
module cache_way
    import cache_pkg::*;
#(
    parameter int LINE_WORDS = 4,
    parameter int SET_DEPTH  = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     read,
    input  logic                     write,
    input  logic [`DATA_WIDTH-1:0]   address,
    input  logic [`DATA_WIDTH-1:0]   writedata,
    input  logic [`DATA_WIDTH/8-1:0] byteenable,
    output logic [`DATA_WIDTH-1:0]   readdata,
    output logic                     hit,
    output logic                     valid,
    output logic                     dirty,
    output logic [`DATA_WIDTH-1:0]   victim_addr,
    output logic                     busy,
    input  logic                     fill_start,
    input  logic [`DATA_WIDTH-1:0]   fill_address,
    input  logic                     fill_valid,
    input  logic [`DATA_WIDTH-1:0]   fill_data,
    output logic                     fill_done,
    input  logic                     evict_start,
    output logic                     evict_valid,
    input  logic                     evict_ready,
    output logic [`DATA_WIDTH-1:0]   evict_data,
    output logic                     evict_last,
    input  logic                     set_nru,
    input  logic                     clr_nru,
    output logic                     nru
);
    localparam int DW     = `DATA_WIDTH;
    localparam int WORD_W = word_bits(LINE_WORDS);
    localparam int SET_W  = set_bits(SET_DEPTH);
    localparam int TAG_W  = tag_bits(DW, LINE_WORDS, SET_DEPTH);
    localparam int AW     = SET_W + WORD_W;
    localparam int OFF_W  = WORD_W + 2;
    localparam beat_cnt_t LAST = beat_cnt_t'(LINE_WORDS - 1);
    localparam logic [AW-1:0] WORD_MASK = AW'(LINE_WORDS - 1);

    cache_way_state_e state, state_n;
    beat_cnt_t cnt, rd_word;
    logic [SET_W-1:0] a_set, f_set, lset;
    logic [TAG_W-1:0] a_tag, f_tag, ltag;
    logic [TAG_W-1:0] tags [SET_DEPTH];
    logic [SET_DEPTH-1:0] valids, dirtys;
    logic ev_valid, fill_beat, fill_last, ev_hs, ev_end, we;
    logic [AW-1:0] line_base, raddr, waddr;
    logic [DW-1:0] wdata, rdata;
    logic [DW/8-1:0] be;
    logic unused_addr;

    assign a_set = address[OFF_W +: SET_W];
    assign a_tag = address[DW-1 -: TAG_W];
    assign f_set = fill_address[OFF_W +: SET_W];
    assign f_tag = fill_address[DW-1 -: TAG_W];
    assign unused_addr = ^{address[1:0], fill_address[OFF_W-1:0], read};
    assign line_base = AW'(lset) << WORD_W;
    // Evict reads run one word ahead on a handshake so the next beat appears without a bubble.
    assign rd_word = ev_hs ? cnt + 1'b1 : cnt;
    assign raddr = state == EVICT ? (line_base | (AW'(rd_word) & WORD_MASK)) : address[2 +: AW];
    assign waddr = state == FILL ? (line_base | (AW'(cnt) & WORD_MASK)) : address[2 +: AW];
    assign we = fill_beat | (write & hit);
    assign wdata = state == FILL ? fill_data : writedata;
    assign be = state == FILL ? '1 : byteenable;
    assign readdata = rdata;
    assign evict_data = rdata;
    assign evict_valid = ev_valid;
    assign valid = valids[a_set];
    assign dirty = dirtys[a_set];
    assign victim_addr = DW'({tags[a_set], a_set}) << OFF_W;

    cache_way_ram #(.DW(DW), .DEPTH(SET_DEPTH * LINE_WORDS), .AW(AW)) u_ram (
        .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdata),
        .we(we), .waddr(waddr), .wdata(wdata), .be(be)
    );

    always_ff @(posedge clk)
        state <= rst ? IDLE : state_n;

    always_comb begin
        state_n = state == IDLE ? (evict_start ? EVICT : fill_start ? FILL : IDLE)
                : state == FILL ? (fill_last ? IDLE : FILL)
                : (ev_end ? IDLE : EVICT);
    end

    always_comb begin
        busy = state != IDLE;
        hit = valids[a_set] && tags[a_set] == a_tag && state == IDLE;
        fill_beat = state == FILL && fill_valid;
        fill_last = fill_beat && cnt == LAST;
        ev_hs = state == EVICT && ev_valid && evict_ready;
        ev_end = ev_hs && cnt == LAST;
        evict_last = ev_valid && cnt == LAST;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            lset <= '0;
            ltag <= '0;
            ev_valid <= 1'b0;
            fill_done <= 1'b0;
            valids <= '0;
            dirtys <= '0;
        end else begin
            fill_done <= fill_last;
            if (state == IDLE && evict_start) begin
                lset <= a_set;
                cnt <= '0;
            end else if (state == IDLE && fill_start) begin
                lset <= f_set;
                ltag <= f_tag;
                cnt <= '0;
                valids[f_set] <= 1'b0;
            end
            if (write && hit) dirtys[a_set] <= 1'b1;
            if (fill_beat) cnt <= fill_last ? '0 : cnt + 1'b1;
            if (fill_last) begin
                tags[lset] <= ltag;
                valids[lset] <= 1'b1;
                dirtys[lset] <= 1'b0;
            end
            if (state == EVICT && !ev_valid) ev_valid <= 1'b1;
            if (ev_hs) cnt <= ev_end ? '0 : cnt + 1'b1;
            if (ev_end) ev_valid <= 1'b0;
        end
    end

`ifdef CACHE_WAY_NRU_EN
    logic [SET_DEPTH-1:0] nru_bits;
    always_ff @(posedge clk) begin
        if (rst) nru_bits <= '1;
        else begin
            if (clr_nru) nru_bits[a_set] <= 1'b0;
            else if (set_nru) nru_bits[a_set] <= 1'b1;
            if (fill_last) nru_bits[lset] <= 1'b0;
        end
    end
    assign nru = nru_bits[a_set];
`else
    logic unused_nru;
    assign unused_nru = set_nru ^ clr_nru;
    assign nru = 1'b0;
`endif
endmodule
